lzc_norm_pipe: RTL and testbench
================================

# lzc_norm_pipe

- Pipelined left-normalizer on the consumer side of the leading-zero counter.
- Accepts a data word together with the counter's inverted count `n_Z` and non-zero flag `n_V`, shifts the word left until its MSB is 1, and returns the normalized word, the true shift amount and a zero flag.
- Sits between the LZC and the mantissa/packing logic.
- Uses a valid/ready handshake at both ends and one barrel-shift level per pipeline stage.

## Interface
Parameters:
- WIDTH, 16, data width; power of two, ≥ 2 (elaboration error otherwise).
- COUNT, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat present.
- in_ready, output, 1, pipeline accepts a beat this cycle.
- in_data, input, WIDTH, word to normalize.
- in_n_z, input, COUNT, LZC inverted count; shift = ~in_n_z.
- in_n_v, input, 1, LZC flag, 1 = in_data has a set bit.
- out_valid, output, 1, result present.
- out_ready, input, 1, downstream accepts.
- out_data, output, WIDTH, normalized word.
- out_shift, output, COUNT, applied shift (leading-zero count).
- out_zero, output, 1, input word was all zeros.
- out_err, output, 1, count/data mismatch (see Configuration).

## Operation
- Shift amount:
  - S = ~in_n_z when in_n_v = 1.
  - S is forced to 0 when in_n_v = 0; out_zero = 1 and out_data = in_data for that beat.
- Pipeline stages:
  - COUNT stages, k = 0..COUNT-1.
  - Stage k shifts left by 2^(COUNT-1-k) when S[COUNT-1-k] = 1, filling from the LSB with zeros.
  - S and the zero flag travel alongside the data.
- Each stage holds a valid bit plus its data, S, zero and err fields.
- Handshake:
  - A stage loads when its output slot is empty or the next stage takes its content in the same cycle (bubble-collapsing).
  - ready_k = !valid_k | ready_{k+1}.
  - in_ready = ready_0.
  - The last stage's ready_{k+1} is out_ready.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - A stage may accept and hand off in the same cycle.
- Ordering: strictly in-order, no drops or duplicates.
- Width rules:
  - All shifts are logical and truncate at WIDTH.
  - out_shift is exactly the S that was applied; no saturation is needed since S ≤ WIDTH-1.
- While out_valid = 1 and out_ready = 0, out_data, out_shift, out_zero and out_err hold stable.

## Timing
- Reset (rst_n low, asynchronous):
  - Every valid bit clears and every data, S and flag register clears to 0.
  - out_valid = 0, out_data = 0, out_shift = 0, out_zero = 0, out_err = 0.
  - in_ready = 1 from the first cycle after release.
- Latency: a beat accepted at edge t appears on out_valid after edge t+COUNT-1 (COUNT cycles of registers) when nothing stalls.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the pipeline fills.
  - in_ready falls in the cycle where every stage is valid and out_ready = 0.
  - Capacity is COUNT beats.
- Simultaneous push and pop on a full pipeline is accepted; there is no bubble.
- Reset mid-operation discards all in-flight beats and produces no partial output.

## Configuration
- LZC_NORM_PIPE_CHECK_EN defined:
  - Final stage computes err = in_n_v ? ~data[WIDTH-1] : (data != 0) on the shifted word.
  - out_err reports it, aligned with the beat.
  - Flags an LZC count that does not match the data.
- Undefined: out_err is tied to 0 and no check logic is built; the port remains.

## Structure
- Package lzc_pkg holds:
  - the parameter-legality function (is_pow2);
  - the count-width localparam helper;
  - a typedef struct for the per-stage payload (data, shift, zero, err).

  The existing LZC adopts the same package.
- One sub-module, lzc_norm_stage:
  - parameters WIDTH and SHAMT;
  - holds valid plus payload and the local ready logic;
  - the top instantiates it COUNT times in a generate loop.

## Test plan
- WIDTH=16, in_data=0x0013, in_n_z=~4'd11, in_n_v=1, out_ready=1 -> after 4 cycles out_data=0x9800, out_shift=11, out_zero=0, out_err=0.
- in_data=0x0000, in_n_v=0, in_n_z=any -> out_data=0x0000, out_shift=0, out_zero=1, out_err=0.
- Back-to-back 0x8000, 0x0001, 0x4000 (shifts 0, 15, 1) at one per cycle -> outputs 0x8000, 0x8000, 0x8000 on consecutive cycles, out_shift 0, 15, 1.
- out_ready=0 with 6 beats offered -> exactly 4 accepted, in_ready low with outputs stable; raise out_ready -> all 6 delivered in order, no loss.
- LZC_NORM_PIPE_CHECK_EN defined, in_data=0x0100, in_n_z=~4'd3 -> out_data=0x0800, out_err=1.
- Assert rst_n low with 3 beats in flight -> out_valid=0 immediately and all outputs 0; after release the next beat emerges alone after COUNT cycles.

Source files
------------

// File: rtl/lzc_norm_pipe_pkg.sv
// Shared definitions for the leading-zero counter and its normalizer pipeline (package lzc_pkg).
// The per-stage payload is sized for the widest supported word; narrower users keep the upper bits at zero.
package lzc_pkg;

  localparam int unsigned LZC_MAX_W = 64;
  localparam int unsigned LZC_MAX_C = 6;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned lzc_count_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  typedef struct packed {
    logic [LZC_MAX_W-1:0] data;
    logic [LZC_MAX_C-1:0] shift;
    logic                 zero;
    logic                 err;
  } lzc_payload_t;

endpackage

// File: rtl/lzc_norm_pipe_stage.sv
// One barrel-shift level of the normalizer: shifts left by SHAMT when that bit of the shift amount is set.
// With LZC_NORM_PIPE_CHECK_EN the final (SHAMT == 1) stage also computes the count/data mismatch flag.
module lzc_norm_stage
  import lzc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHAMT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  lzc_payload_t pay_i,
  output logic         valid_o,
  input  logic         ready_i,
  output lzc_payload_t pay_o
);

  localparam int unsigned          SEL  = $clog2(SHAMT);
  localparam logic [LZC_MAX_W-1:0] MASK = {LZC_MAX_W{1'b1}} >> (LZC_MAX_W - WIDTH);

  logic         valid_q;
  lzc_payload_t pay_q;
  lzc_payload_t pay_d;

  // Loads when empty or when the next stage drains us in the same cycle.
  assign ready_o = !valid_q || ready_i;

  always_comb begin
    pay_d = pay_i;
    if (pay_i.shift[SEL]) begin
      pay_d.data = (pay_i.data << SHAMT) & MASK;
    end
`ifdef LZC_NORM_PIPE_CHECK_EN
    if (SHAMT == 1) begin
      pay_d.err = pay_i.zero ? (pay_d.data != '0) : ~pay_d.data[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        pay_q <= pay_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/lzc_norm_pipe.sv
// Pipelined left-normalizer fed by the LZC's inverted count and non-zero flag; one shift level per stage.
// Optional macro LZC_NORM_PIPE_CHECK_EN drives out_err with a count/data mismatch check; otherwise out_err is 0.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned COUNT = lzc_count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [COUNT-1:0] in_n_z,
  input  logic             in_n_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [COUNT-1:0] out_shift,
  output logic             out_zero,
  output logic             out_err
);

  if (!is_pow2(WIDTH) || (WIDTH < 2) || (WIDTH > LZC_MAX_W)) begin : g_bad_width
    $error("lzc_norm_pipe: WIDTH must be a power of two in [2, %0d]", LZC_MAX_W);
  end

  logic [COUNT-1:0] s_amt;
  lzc_payload_t     pay_in;
  lzc_payload_t     pay_out;
  logic             unused_hi;

  assign s_amt = in_n_v ? ~in_n_z : '0;

  always_comb begin
    pay_in       = '0;
    pay_in.data  = LZC_MAX_W'(in_data);
    pay_in.shift = LZC_MAX_C'(s_amt);
    pay_in.zero  = ~in_n_v;
  end

  // Stage k handles shift bit COUNT-1-k, so the largest shift happens first.
  for (genvar k = 0; k < COUNT; k++) begin : g_stage
    logic         vin;
    logic         rdy;
    logic         vld;
    logic         rnxt;
    lzc_payload_t pin;
    lzc_payload_t pay;

    if (k == 0) begin : g_head
      assign vin = in_valid;
      assign pin = pay_in;
    end else begin : g_body
      assign vin = g_stage[k-1].vld;
      assign pin = g_stage[k-1].pay;
    end

    if (k == COUNT - 1) begin : g_tail
      assign rnxt = out_ready;
    end else begin : g_mid
      assign rnxt = g_stage[k+1].rdy;
    end

    lzc_norm_stage #(
      .WIDTH (WIDTH),
      .SHAMT (32'd1 << (COUNT - 1 - k))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (vin),
      .ready_o (rdy),
      .pay_i   (pin),
      .valid_o (vld),
      .ready_i (rnxt),
      .pay_o   (pay)
    );
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[COUNT-1].vld;
  assign pay_out   = g_stage[COUNT-1].pay;
  assign out_data  = pay_out.data[WIDTH-1:0];
  assign out_shift = pay_out.shift[COUNT-1:0];
  assign out_zero  = pay_out.zero;

`ifdef LZC_NORM_PIPE_CHECK_EN
  assign out_err   = pay_out.err;
  assign unused_hi = ^{pay_out.data >> WIDTH, pay_out.shift >> COUNT};
`else
  assign out_err   = 1'b0;
  assign unused_hi = ^{pay_out.data >> WIDTH, pay_out.shift >> COUNT, pay_out.err};
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed self-checking bench for lzc_norm_pipe at WIDTH=16 (COUNT=4).
// Expected out_err follows LZC_NORM_PIPE_CHECK_EN when the bench is built with it.
module tb_lzc_norm_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned COUNT = 4;
`ifdef LZC_NORM_PIPE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [COUNT-1:0] in_n_z;
  logic             in_n_v;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [COUNT-1:0] out_shift;
  logic             out_zero;
  logic             out_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  lzc_norm_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_n_z    (in_n_z),
    .in_n_v    (in_n_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] ed, input logic [3:0] es,
                           input logic ez, input logic ee);
    check({tag, "_data"},  32'(out_data),  32'(ed));
    check({tag, "_shift"}, 32'(out_shift), 32'(es));
    check({tag, "_zero"},  32'(out_zero),  32'(ez));
    check({tag, "_err"},   32'(out_err),   32'(ee));
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] nz, input logic nv);
    in_valid = v;
    in_data  = d;
    in_n_z   = nz;
    in_n_v   = nv;
  endtask

  // One isolated beat: checks acceptance, exact latency, the result and that nothing follows it.
  task automatic single(input string tag, input logic [15:0] d, input logic [3:0] nz, input logic nv,
                        input logic [15:0] ed, input logic [3:0] es, input logic ez, input logic ee);
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, d, nz, nv);
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_out(tag, ed, es, ez, ee);
    @(negedge clk);
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] b2b_d  [3] = '{16'h8000, 16'h0001, 16'h4000};
  logic [3:0]  b2b_s  [3] = '{4'd0, 4'd15, 4'd1};

  logic [15:0] bp_d   [6] = '{16'h0001, 16'h00F0, 16'h1234, 16'h0000, 16'h0ABC, 16'h7FFF};
  logic [3:0]  bp_nz  [6] = '{~4'd15,   ~4'd8,    ~4'd3,    4'h5,     ~4'd4,    ~4'd1};
  logic        bp_nv  [6] = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
  logic [15:0] bp_ed  [6] = '{16'h8000, 16'hF000, 16'h91A0, 16'h0000, 16'hABC0, 16'hFFFE};
  logic [3:0]  bp_es  [6] = '{4'd15,    4'd8,     4'd3,     4'd0,     4'd4,     4'd1};
  logic        bp_ez  [6] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0};

  initial begin
    int unsigned acc;
    int unsigned got;
    logic        in_x;
    logic        out_x;

    drive(1'b0, 16'h0, 4'h0, 1'b0);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check_out("rst", 16'h0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    single("basic", 16'h0013, ~4'd11, 1'b1, 16'h9800, 4'd11, 1'b0, 1'b0);
    single("zero",  16'h0000, 4'h0,   1'b0, 16'h0000, 4'd0,  1'b1, 1'b0);
    single("chk",   16'h0100, ~4'd3,  1'b1, 16'h0800, 4'd3,  1'b0, CHK);

    // Back-to-back beats emerge on consecutive cycles.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b2b_d[i], ~b2b_s[i], 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      check_out($sformatf("b2b%0d", i), 16'h8000, b2b_s[i], 1'b0, 1'b0);
      @(negedge clk);
    end
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: fill with out_ready low, then drain while offering the rest.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 6) drive(1'b1, bp_d[acc], bp_nz[acc], bp_nv[acc]);
      else         drive(1'b0, 16'h0, 4'h0, 1'b0);
      #1 in_x = in_valid && in_ready;
      @(posedge clk);
      if (in_x) acc++;
      @(negedge clk);
    end
    check("bp_accepted", acc, 32'd4);
    #1 check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check_out("bp_hold0", bp_ed[0], bp_es[0], bp_ez[0], 1'b0);
    @(negedge clk);
    check_out("bp_hold1", bp_ed[0], bp_es[0], bp_ez[0], 1'b0);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (acc < 6) drive(1'b1, bp_d[acc], bp_nz[acc], bp_nv[acc]);
      else         drive(1'b0, 16'h0, 4'h0, 1'b0);
      #1;
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        check_out($sformatf("bp%0d", got), bp_ed[got], bp_es[got], bp_ez[got], 1'b0);
        got++;
      end
      @(posedge clk);
      if (in_x) acc++;
      @(negedge clk);
    end
    check("bp_delivered", got, 32'd6);
    check("bp_all_accepted", acc, 32'd6);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    drive(1'b1, 16'h0013, ~4'd11, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h0001, ~4'd15, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h00F0, ~4'd8, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_data", 32'(out_data), 32'h9800);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check_out("mid_rst", 16'h0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_post_idle", 32'(out_valid), 32'd0);
    single("post", 16'h4000, ~4'd1, 1'b1, 16'h8000, 4'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
